ipm_burst_sequencer: RTL and testbench
======================================

IPM_BURST_SEQUENCER -- requirements
Module: ipm_burst_sequencer

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH_PTR, default 6, pointer width; DATA_WIDTH, default 32, data-bus width; LEN_WIDTH, default 7, burst-length width.
REQ-002 SHALL have these ports:
- clk  in  1  single clock, rising edge.
- rst_a  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  00=write MEM_IN, 01=read MEM_OUT, 10=write CONF_REG, 11=reserved.
- cmd_ptr  in  ADDR_WIDTH_PTR  start pointer.
- cmd_len  in  LEN_WIDTH  beat count.
- wdata_valid / wdata_ready  in / out  1  write-data stream handshake.
- wdata  in  DATA_WIDTH  write beat.
- rdata_valid / rdata_ready  out / in  1  read-data stream handshake.
- rdata  out  DATA_WIDTH  read beat.
- en_s, write, read  out  1  interface strobes.
- conf_dbus  out  5  interface action code.
- init_ptr  out  ADDR_WIDTH_PTR  pointer load value.
- data_out  out  DATA_WIDTH  bus write data.
- data_in  in  DATA_WIDTH  bus read data.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse at command end.

Function
REQ-003 SHALL implement states IDLE, SET_PTR, XFER, DRAIN, DONE (plus POLL, CLEAR per REQ-016).
REQ-004 IDLE: cmd_ready=1; cmd_valid&cmd_ready SHALL latch op/ptr/len; next state SET_PTR, or DONE if cmd_len=0 (no bus activity).
REQ-005 SET_PTR SHALL last exactly one cycle: write=1, init_ptr=latched ptr, conf_dbus=00100 (op 00), 00101 (op 01), 00011 (op 10); then XFER.
REQ-006 Op 11 SHALL be accepted, cause no bus activity, and go directly to DONE.
REQ-007 XFER write ops: wdata_ready=1; each cycle with wdata_valid SHALL drive write=1, data_out=wdata, conf_dbus=00001 (MEM_IN) or 00000 (CONF_REG), and decrement the beat counter; no write strobe on cycles without wdata_valid.
REQ-008 XFER read op: read=1, conf_dbus=00010 only when the single-entry read buffer is empty, or will empty this cycle (rdata_valid&rdata_ready), and beats remain.
REQ-009 data_in SHALL be valid the cycle after a read strobe and SHALL be captured into the read buffer that cycle; rdata_valid holds until rdata_ready.
REQ-010 Last write beat -> DONE; last read strobe -> DRAIN; DRAIN -> DONE once the buffer is empty.
REQ-011 DONE SHALL assert done for exactly one cycle, then IDLE.
REQ-012 en_s SHALL equal busy; conf_dbus SHALL be 11111 (ID_REG) and write=read=0 whenever no strobe is issued.
REQ-013 Beat counter SHALL be LEN_WIDTH bits; pointer wrap past memory depth is the interface's modulo behaviour, not checked here.
REQ-014 cmd_valid while busy SHALL be ignored (cmd_ready=0); wdata_ready=0 outside write XFER.

Reset
REQ-015 rst_a low SHALL immediately force IDLE, empty the read buffer, clear the counter, and drive cmd_ready=1, all other outputs 0 except conf_dbus=11111, including mid-burst.

Configuration
REQ-016 With STATUS_POLL_EN defined, op 01 SHALL pass through POLL after SET_PTR: read=1, conf_dbus=11110 each cycle until data_in[0]=1 (sampled next cycle), then XFER; after DRAIN, CLEAR issues one write with conf_dbus=11110, then DONE. Without STATUS_POLL_EN, POLL and CLEAR SHALL not exist and op 01 goes SET_PTR->XFER.

Structure
REQ-017 conf_dbus codes, cmd_op encodings and the state enumeration SHALL live in shared package ipm_seq_pkg.
REQ-018 The single-entry read buffer SHALL be sub-module ipm_seq_rbuf (DATA_WIDTH, valid/ready in and out).

Verification
REQ-019 Write MEM_IN ptr=5 len=3, wdata 0xA,0xB,0xC back-to-back -> SET_PTR write init_ptr=5 conf 00100, three write strobes conf 00001, done at cycle 6 after accept.
REQ-020 Read MEM_OUT ptr=0 len=4, rdata_ready low 3 cycles after first beat -> read strobes stall, exactly 4 rdata beats in order, no loss.
REQ-021 cmd_len=0 and cmd_op=11 -> no write/read strobe, done 1 cycle after accept.
REQ-022 rst_a low during beat 2 of a len=8 write -> outputs at reset values asynchronously; new command accepted after release.
REQ-023 STATUS_POLL_EN, data_in[0] held 0 for 5 polls then 1 -> 6 polls, then reads, then one STAT_REG write, then done.
REQ-024 cmd_valid pulsed during busy -> ignored, cmd_ready=0, no second done.

Source files
------------

// File: rtl/ipm_seq_pkg.sv
// Shared encodings for the IPM burst sequencer: bus action codes, command ops and FSM states.
// The POLL/CLEAR states only exist when STATUS_POLL_EN is defined.
package ipm_seq_pkg;

  typedef enum logic [1:0] {
    OP_WR_MEM  = 2'b00,
    OP_RD_MEM  = 2'b01,
    OP_WR_CONF = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_PTR = 3'd1,
    S_XFER    = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
`ifdef STATUS_POLL_EN
    ,
    S_POLL    = 3'd5,
    S_CLEAR   = 3'd6
`endif
  } state_e;

  localparam logic [4:0] CONF_CONF_DATA = 5'b00000;
  localparam logic [4:0] CONF_MEM_IN    = 5'b00001;
  localparam logic [4:0] CONF_MEM_OUT   = 5'b00010;
  localparam logic [4:0] CONF_PTR_CONF  = 5'b00011;
  localparam logic [4:0] CONF_PTR_IN    = 5'b00100;
  localparam logic [4:0] CONF_PTR_OUT   = 5'b00101;
  localparam logic [4:0] CONF_STAT      = 5'b11110;
  localparam logic [4:0] CONF_ID        = 5'b11111;

  // Pointer-load action code for the SET_PTR cycle of each op.
  function automatic logic [4:0] ptr_code(input op_e op);
    case (op)
      OP_RD_MEM:  return CONF_PTR_OUT;
      OP_WR_CONF: return CONF_PTR_CONF;
      default:    return CONF_PTR_IN;
    endcase
  endfunction

endpackage

// File: rtl/ipm_seq_rbuf.sv
// Single-entry read buffer between the bus read return and the rdata stream.
// Can take a new beat in the same cycle the held one is consumed.
module ipm_seq_rbuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ipm_burst_sequencer.sv
// Burst sequencer: turns pointer/length commands into IPM bus strobe sequences.
// Define STATUS_POLL_EN to add status polling before reads and a status clear after them.
module ipm_burst_sequencer
  import ipm_seq_pkg::*;
#(
  parameter int ADDR_WIDTH_PTR = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 7
) (
  input  logic                      clk,
  input  logic                      rst_a,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [ADDR_WIDTH_PTR-1:0] cmd_ptr,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic                      rdata_valid,
  input  logic                      rdata_ready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      en_s,
  output logic                      write,
  output logic                      read,
  output logic [4:0]                conf_dbus,
  output logic [ADDR_WIDTH_PTR-1:0] init_ptr,
  output logic [DATA_WIDTH-1:0]     data_out,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic                      busy,
  output logic                      done
);

  state_e                    r_state, w_next;
  op_e                       r_op;
  logic [ADDR_WIDTH_PTR-1:0] r_ptr;
  logic [LEN_WIDTH-1:0]      r_cnt;
  logic                      r_rd_pend;
  logic                      w_accept, w_wr_op, w_wr_beat, w_rd_beat, w_last;
  logic                      w_rb_in_ready;
`ifdef STATUS_POLL_EN
  logic                      r_poll_pend;
  logic                      w_stat_ok;
  assign w_stat_ok = r_poll_pend && data_in[0];
`endif

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_wr_op   = (r_op != OP_RD_MEM);
  assign w_wr_beat = (r_state == S_XFER) && w_wr_op && wdata_valid;
  // A strobed beat still in flight counts as buffer occupancy.
  assign w_rd_beat = (r_state == S_XFER) && !w_wr_op && !r_rd_pend && w_rb_in_ready;
  assign w_last    = (r_cnt == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_op      <= OP_WR_MEM;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= op_e'(cmd_op);
        r_ptr <= cmd_ptr;
        r_cnt <= cmd_len;
      end else if (w_wr_beat || w_rd_beat) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_rd_pend <= w_rd_beat;
    end
  end

`ifdef STATUS_POLL_EN
  // Status returns one cycle after each poll strobe.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) r_poll_pend <= 1'b0;
    else        r_poll_pend <= (r_state == S_POLL) && !w_stat_ok;
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (cmd_valid)
          w_next = (cmd_len == '0 || cmd_op == OP_RSVD) ? S_DONE : S_SET_PTR;
      S_SET_PTR:
`ifdef STATUS_POLL_EN
        w_next = (r_op == OP_RD_MEM) ? S_POLL : S_XFER;
      S_POLL:
        if (w_stat_ok) w_next = S_XFER;
      S_CLEAR:
        w_next = S_DONE;
`else
        w_next = S_XFER;
`endif
      S_XFER:
        if ((w_wr_beat || w_rd_beat) && w_last)
          w_next = w_wr_op ? S_DONE : S_DRAIN;
      S_DRAIN:
        if (!r_rd_pend && !rdata_valid)
`ifdef STATUS_POLL_EN
          w_next = S_CLEAR;
`else
          w_next = S_DONE;
`endif
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    write       = 1'b0;
    read        = 1'b0;
    conf_dbus   = CONF_ID;
    init_ptr    = '0;
    data_out    = '0;
    case (r_state)
      S_IDLE: cmd_ready = 1'b1;
      S_SET_PTR: begin
        write     = 1'b1;
        init_ptr  = r_ptr;
        conf_dbus = ptr_code(r_op);
      end
      S_XFER:
        if (w_wr_op) begin
          wdata_ready = 1'b1;
          if (wdata_valid) begin
            write     = 1'b1;
            data_out  = wdata;
            conf_dbus = (r_op == OP_WR_MEM) ? CONF_MEM_IN : CONF_CONF_DATA;
          end
        end else if (w_rd_beat) begin
          read      = 1'b1;
          conf_dbus = CONF_MEM_OUT;
        end
`ifdef STATUS_POLL_EN
      S_POLL:
        if (!w_stat_ok) begin
          read      = 1'b1;
          conf_dbus = CONF_STAT;
        end
      S_CLEAR: begin
        write     = 1'b1;
        conf_dbus = CONF_STAT;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign en_s = busy;
  assign done = (r_state == S_DONE);

  ipm_seq_rbuf #(.DATA_WIDTH(DATA_WIDTH)) u_rbuf (
    .clk     (clk),
    .rst_a   (rst_a),
    .i_valid (r_rd_pend),
    .o_ready (w_rb_in_ready),
    .i_data  (data_in),
    .o_valid (rdata_valid),
    .i_ready (rdata_ready),
    .o_data  (rdata)
  );

endmodule

// File: tb/tb_ipm_burst_sequencer.sv
// Scoreboard bench for ipm_burst_sequencer: expected bus strobes and read beats are queued
// at command issue and consumed as the DUT produces them.
`timescale 1ns/1ps
module tb_ipm_burst_sequencer;
  localparam int AW = 6, DW = 32, LW = 7, POLL_N = 6;

  logic          clk = 1'b0;
  logic          rst_a;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_ptr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready;
  logic [DW-1:0] rdata;
  logic          en_s, write, read, busy, done;
  logic [4:0]    conf_dbus;
  logic [AW-1:0] init_ptr;
  logic [DW-1:0] data_out, data_in;

  always #5 clk = ~clk;

  ipm_burst_sequencer #(.ADDR_WIDTH_PTR(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_a(rst_a),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ptr(cmd_ptr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .en_s(en_s), .write(write), .read(read), .conf_dbus(conf_dbus), .init_ptr(init_ptr),
    .data_out(data_out), .data_in(data_in), .busy(busy), .done(done)
  );

  typedef struct {
    logic        wr;
    logic        isptr;
    logic [4:0]  conf;
    logic [31:0] val;
  } ev_t;

  ev_t         ev_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wq[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  int wr_beats = 0, rd_beats = 0, rr_hold = 0, poll_cnt = 0;
  bit stall_arm = 0, rr_rand = 0, wgap = 0, took = 0, rsp_pend = 0;
  logic [31:0]   rsp_val = '0;
  logic [AW-1:0] rd_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  function automatic void push_ev(input logic wr, input logic isptr, input logic [4:0] conf,
                                  input logic [31:0] val);
    ev_t e;
    e.wr = wr; e.isptr = isptr; e.conf = conf; e.val = val;
    ev_q.push_back(e);
  endfunction

  task automatic push_read(input logic [AW-1:0] p, input int len);
    push_ev(1'b1, 1'b1, 5'b00101, 32'(p));
`ifdef STATUS_POLL_EN
    for (int i = 0; i < POLL_N; i++) push_ev(1'b0, 1'b0, 5'b11110, 32'h0);
`endif
    for (int i = 0; i < len; i++) begin
      push_ev(1'b0, 1'b0, 5'b00010, 32'h0);
      rd_q.push_back(mem_val(p + AW'(i)));
    end
`ifdef STATUS_POLL_EN
    push_ev(1'b1, 1'b0, 5'b11110, 32'h0);
`endif
  endtask

  task automatic push_write(input logic [1:0] op, input logic [AW-1:0] p, input int len);
    logic [31:0] v;
    push_ev(1'b1, 1'b1, (op == 2'b10) ? 5'b00011 : 5'b00100, 32'(p));
    for (int i = 0; i < len; i++) begin
      v = $urandom;
      wq.push_back(v);
      push_ev(1'b1, 1'b0, (op == 2'b10) ? 5'b00000 : 5'b00001, v);
    end
  endtask

  // Bus monitor, memory model and scoreboard consumer; samples on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    took     = wdata_valid && wdata_ready;
    rsp_pend = 1'b0;
    if (rst_a) begin
      if (write || read) begin
        if (ev_q.size() == 0) chk("unexp_strobe", {25'h0, write, read, conf_dbus}, 32'h0);
        else begin
          e = ev_q.pop_front();
          chk("ev_write", 32'(write), 32'(e.wr));
          chk("ev_read", 32'(read), 32'(!e.wr));
          chk("ev_conf", 32'(conf_dbus), 32'(e.conf));
          chk("ev_val", e.isptr ? 32'(init_ptr) : data_out, e.val);
        end
      end else chk("idle_conf", 32'(conf_dbus), 32'h1F);
      if (!busy) chk("idle_wrdy", 32'(wdata_ready), 32'h0);
      if (write && (conf_dbus == 5'b00001 || conf_dbus == 5'b00000)) wr_beats++;
      if (write && conf_dbus == 5'b00101) begin rd_addr = init_ptr; poll_cnt = 0; end
      if (read && conf_dbus == 5'b00010) begin
        rsp_pend = 1'b1; rsp_val = mem_val(rd_addr); rd_addr = rd_addr + 1'b1;
      end
      if (read && conf_dbus == 5'b11110) begin
        poll_cnt++; rsp_pend = 1'b1; rsp_val = (poll_cnt >= POLL_N) ? 32'h1 : 32'h0;
      end
      if (rdata_valid && !rdata_ready) chk("rd_stall", 32'(read), 32'h0);
      if (rdata_valid && rdata_ready) begin
        rd_beats++;
        if (rd_q.size() == 0) chk("unexp_rdata", rdata, 32'hFFFF_FFFF);
        else chk("rdata", rdata, rd_q.pop_front());
        if (stall_arm) begin stall_arm = 0; rr_hold = 3; end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Write-data source, read-return driver and rdata_ready pattern.
  initial begin
    wdata_valid = 1'b0; wdata = '0; data_in = '0; rdata_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (took && wq.size() > 0) void'(wq.pop_front());
      wdata_valid = (wq.size() > 0) && (!wgap || $urandom_range(0, 2) != 0);
      wdata       = wdata_valid ? wq[0] : $urandom;
      data_in     = rsp_pend ? rsp_val : 32'hBAD0_0000;
      if (rr_hold > 0) begin rdata_ready = 1'b0; rr_hold--; end
      else rdata_ready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] p, input logic [LW-1:0] len);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_ptr = p; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    chk("cmd_accept", 32'(cmd_ready), 32'h1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n0, t;
    n0 = done_cnt; t = 0;
    while (done_cnt == n0 && t < 400) begin @(posedge clk); t++; end
    if (done_cnt == n0) chk({tag, "_timeout"}, 32'h0, 32'h1);
    else if (exp_lat >= 0) chk(tag, 32'(done_cyc - acc_cyc), 32'(exp_lat));
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_ev_left"}, 32'(ev_q.size()), 32'h0);
    chk({tag, "_rd_left"}, 32'(rd_q.size()), 32'h0);
    chk({tag, "_wq_left"}, 32'(wq.size()), 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_en_s"}, 32'(en_s), 32'h0);
    chk({tag, "_write"}, 32'(write), 32'h0);
    chk({tag, "_read"}, 32'(read), 32'h0);
    chk({tag, "_conf"}, 32'(conf_dbus), 32'h1F);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_wrdy"}, 32'(wdata_ready), 32'h0);
    chk({tag, "_rvalid"}, 32'(rdata_valid), 32'h0);
    chk({tag, "_init_ptr"}, 32'(init_ptr), 32'h0);
    chk({tag, "_data_out"}, data_out, 32'h0);
  endtask

  initial begin
    int d0, b0, t;
    rst_a = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ptr = '0; cmd_len = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    @(negedge clk) rst_a = 1'b1;

    // Write MEM_IN ptr=5 len=3, back-to-back data; accept cycle counts as cycle 1.
    push_ev(1'b1, 1'b1, 5'b00100, 32'd5);
    push_ev(1'b1, 1'b0, 5'b00001, 32'hA); push_ev(1'b1, 1'b0, 5'b00001, 32'hB);
    push_ev(1'b1, 1'b0, 5'b00001, 32'hC);
    wq.push_back(32'hA); wq.push_back(32'hB); wq.push_back(32'hC);
    send_cmd(2'b00, 6'd5, 7'd3);
    wait_done("wr3_done_lat", 5);
    check_empty("wr3");

    // Read MEM_OUT ptr=0 len=4 with rdata_ready low for 3 cycles after the first beat.
    b0 = rd_beats; stall_arm = 1;
    push_read(6'd0, 4);
    send_cmd(2'b01, 6'd0, 7'd4);
    wait_done("rd4_done", -1);
    chk("rd4_beats", 32'(rd_beats - b0), 32'd4);
    check_empty("rd4");

    // Zero length and reserved op: no strobes, done right after accept.
    send_cmd(2'b00, 6'd9, 7'd0);
    wait_done("len0_lat", 1);
    send_cmd(2'b11, 6'd9, 7'd4);
    wait_done("op3_lat", 1);
    check_empty("nop");

    // Command pulsed while busy must be ignored.
    wgap = 1; d0 = done_cnt;
    push_write(2'b10, 6'd7, 4);
    send_cmd(2'b10, 6'd7, 7'd4);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 7'd1;
    @(negedge clk);
    chk("busy_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("busy_flag", 32'(busy), 32'h1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_done("busy_done", -1);
    repeat (12) @(posedge clk);
    chk("busy_done_count", 32'(done_cnt - d0), 32'h1);
    check_empty("busy");

    // Mixed commands with bubbly write data and random rdata_ready.
    rr_rand = 1;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] op; logic [AW-1:0] p; logic [LW-1:0] l;
      op = 2'($urandom_range(0, 2)); p = AW'($urandom); l = LW'($urandom_range(1, 6));
      if (op == 2'b01) push_read(p, int'(l)); else push_write(op, p, int'(l));
      send_cmd(op, p, l);
      wait_done("rnd_done", -1);
      check_empty("rnd");
    end
    rr_rand = 0; wgap = 0;

    // Asynchronous reset during beat 2 of a len=8 write.
    b0 = wr_beats;
    push_write(2'b00, 6'd20, 8);
    send_cmd(2'b00, 6'd20, 7'd8);
    t = 0;
    while (wr_beats < b0 + 2 && t < 100) begin @(negedge clk); #1; t++; end
    chk("pre_rst_beats", 32'(wr_beats - b0), 32'd2);
    chk("pre_rst_write", 32'(write), 32'h1);
    #1 rst_a = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    ev_q.delete(); rd_q.delete(); wq.delete(); took = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_a = 1'b1;
    push_write(2'b00, 6'd1, 2);
    send_cmd(2'b00, 6'd1, 7'd2);
    wait_done("post_rst_lat", 4);
    check_empty("post_rst");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
